instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 98 +++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues word fetches to instruction memory, buffers
// up to two in-order responses and hands them to the decoder with a valid/ready handshake.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  op,
    output logic [2:0]  func3,
    output logic [6:0]  func7
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } fetch_ent_t;

    logic [31:0] pc_q;
    fetch_ent_t  fifo_q [2];
    logic        rd_q, wr_q;
    logic [1:0]  cnt_q, out_q, drop_q;

    logic        pop, rsp, push, grant;
    logic [2:0]  credit;
    logic [31:0] rsp_pc;
    fetch_ent_t  head;
    logic        unused_rpc_bits;

    assign unused_rpc_bits = ^redirect_pc[1:0];

    always_comb begin
        head        = fifo_q[rd_q];
        instr_valid = rst & (cnt_q != 2'd0);
        pop         = instr_valid & instr_ready;
        rsp         = imem_rvalid & (out_q != 2'd0);
        push        = rst & rsp & (drop_q == 2'd0) & ~redirect;
        // A slot freed by a same-cycle pop counts as credit, so a 1-cycle memory streams every cycle
        credit      = {1'b0, cnt_q} - {2'b00, pop} + {1'b0, out_q};
        imem_req    = rst & ~redirect & (credit < 3'd2);
        grant       = imem_req & imem_gnt;
        imem_addr   = pc_q;
        // Once stale responses are gone, the oldest outstanding fetch is pc_q - 4*out_q
        rsp_pc      = pc_q - {28'd0, out_q, 2'b00};
        instr       = instr_valid ? head.data : NOP;
        instr_pc    = instr_valid ? head.pc : (rst ? pc_q : RESET_PC);
    end

    assign op    = instr[6:0];
    assign func3 = instr[14:12];
    assign func7 = instr[31:25];

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q   <= RESET_PC;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            cnt_q  <= 2'd0;
            out_q  <= 2'd0;
            drop_q <= 2'd0;
        end else begin
            out_q <= out_q + {1'b0, grant} - {1'b0, rsp};
            if (redirect) begin
                pc_q   <= {redirect_pc[31:2], 2'b00};
                rd_q   <= 1'b0;
                wr_q   <= 1'b0;
                cnt_q  <= 2'd0;
                drop_q <= out_q - {1'b0, rsp};
            end else begin
                if (grant)
                    pc_q <= pc_q + 32'd4;
                if (rsp && drop_q != 2'd0)
                    drop_q <= drop_q - 2'd1;
                if (push)
                    wr_q <= ~wr_q;
                if (pop)
                    rd_q <= ~rd_q;
                cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_q] <= '{data: imem_rdata, pc: rsp_pc};
    end
endmodule
